// File: rtl/my_pkg.sv
// Shared fetch-stage types.
//   PCSrc_Enum    : next-PC source select driven by hazard/branch control
//   fetch_state_e : instruction fetch FSM state encoding
//   NOP_INSTR     : instruction word presented on instr_o after reset (addi x0,x0,0)
package my_pkg;

    typedef enum logic [2:0] {
        next_pc        = 3'd0,
        branch_alu     = 3'd1,
        branch_pc_jump = 3'd2,
        trap_illegal   = 3'd3,
        xepc           = 3'd4
    } PCSrc_Enum;

    typedef enum logic [1:0] {
        FETCH_REQ   = 2'd0,
        FETCH_WAIT  = 2'd1,
        FETCH_VALID = 2'd2,
        FETCH_DROP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_fsm_pc_next_sel.sv
// Next-PC datapath: redirect target mux plus sequential PC+4 adder.
//   pc          in  current fetch PC
//   PCSrc       in  redirect source select
//   alu_target  in  branch target computed by the ALU
//   jump_target in  jump target
//   xepc_value  in  exception return address
//   target      out selected redirect target, word aligned
//   pc_plus4    out pc + 4, wraps modulo 2^32
module pc_next_sel
    import my_pkg::*;
#(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
    input  logic [31:0] pc,
    input  PCSrc_Enum   PCSrc,
    input  logic [31:0] alu_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] xepc_value,
    output logic [31:0] target,
    output logic [31:0] pc_plus4
);

    logic [31:0] raw_target;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        raw_target = pc_plus4;
        case (PCSrc)
            branch_alu:     raw_target = alu_target;
            branch_pc_jump: raw_target = jump_target;
            trap_illegal:   raw_target = TRAP_VEC;
            xepc:           raw_target = xepc_value;
            default:        raw_target = pc_plus4;
        endcase
    end

    assign target = {raw_target[31:2], 2'b00};

endmodule

// File: rtl/instr_fetch_fsm.sv
// Instruction fetch FSM: issues one instruction-memory request at a time,
// holds the returned word for IF/ID, and handles PC redirects at any point
// of a transaction (squashed responses are drained in DROP).
//   clk, rst_n        clock / synchronous active-low reset
//   En_PC, PCSrc      PC update enable and next-PC source from hazard control
//   alu_target, jump_target, xepc_value  redirect targets
//   imem_req/addr/gnt/rvalid/rdata       instruction-memory handshake
//   instr_o, pc_o     fetched instruction and its PC
//   I_FSM_STALL_FETCH high while instr_o/pc_o hold a valid instruction
module instr_fetch_fsm
    import my_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        En_PC,
    input  PCSrc_Enum   PCSrc,
    input  logic [31:0] alu_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] xepc_value,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        I_FSM_STALL_FETCH
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;
    logic         redirect;

    pc_next_sel #(.TRAP_VEC(TRAP_VEC)) u_pc_next_sel (
        .pc          (pc),
        .PCSrc       (PCSrc),
        .alu_target  (alu_target),
        .jump_target (jump_target),
        .xepc_value  (xepc_value),
        .target      (target),
        .pc_plus4    (pc_plus4)
    );

    assign redirect          = En_PC && (PCSrc != next_pc);
    assign imem_req          = (state == FETCH_REQ);
    assign imem_addr         = pc;
    assign I_FSM_STALL_FETCH = (state == FETCH_VALID);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= FETCH_REQ;
            pc      <= RESET_PC;
            instr_o <= NOP_INSTR;
            pc_o    <= RESET_PC;
        end else begin
            if (redirect) begin
                pc <= target;
            end
            case (state)
                FETCH_REQ: begin
                    // A redirect coinciding with gnt leaves a response in flight.
                    if (imem_gnt) begin
                        state <= redirect ? FETCH_DROP : FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (redirect) begin
                        state <= imem_rvalid ? FETCH_REQ : FETCH_DROP;
                    end else if (imem_rvalid) begin
                        instr_o <= imem_rdata;
                        pc_o    <= pc;
                        state   <= FETCH_VALID;
                    end
                end
                FETCH_VALID: begin
                    if (redirect) begin
                        state <= FETCH_REQ;
                    end else if (En_PC) begin
                        pc    <= pc_plus4;
                        state <= FETCH_REQ;
                    end
                end
                FETCH_DROP: begin
                    if (imem_rvalid) begin
                        state <= FETCH_REQ;
                    end
                end
                default: state <= FETCH_REQ;
            endcase
        end
    end

endmodule
